qslice_n: RTL

QSLICE_N -- requirements
Module: qslice_n

---
 rtl/qslice_pkg.sv | 20 ++
 rtl/qslice_n_if.sv | 25 ++
 rtl/qslice_n_fp_sync.sv | 42 ++++
 rtl/qslice_n.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/qslice_pkg.sv
// Shared types for the qslice_n CPU slice: front-panel FSM states and the
// X-register source select encodings.
package qslice_pkg;

    typedef enum logic [2:0] {
        FP_IDLE     = 3'd0,
        FP_DEP_WR   = 3'd1,
        FP_EXAM_RD  = 3'd2,
        FP_INC      = 3'd3,
        FP_WAIT_REL = 3'd4
    } fp_state_e;

    typedef enum logic [1:0] {
        XSEL_ZERO  = 2'd0,
        XSEL_SHIFT = 2'd1,
        XSEL_P     = 2'd2,
        XSEL_DBUS  = 2'd3
    } xsel_e;

endpackage

// File: rtl/qslice_n_if.sv
// Memory/data bus and CPU register strobe bundle for qslice_n; the CPU side
// (master) drives strobes and read data, the slice (slave) drives the bus.
interface qslice_n_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] dbus_i;
    logic [WIDTH-1:0] dbus_o;
    logic             dbus_oe;
    logic [WIDTH-1:0] abus_o;
    logic             mem_wr;
    logic             mem_rd;
    logic             wra, rda, wrx, rdx, wrp, rdp, incp, wrs;
    logic [1:0]       xsel;
    logic             sin;

    modport master (
        output dbus_i, wra, rda, wrx, rdx, wrp, rdp, incp, wrs, xsel, sin,
        input  dbus_o, dbus_oe, abus_o, mem_wr, mem_rd
    );

    modport slave (
        input  dbus_i, wra, rda, wrx, rdx, wrp, rdp, incp, wrs, xsel, sin,
        output dbus_o, dbus_oe, abus_o, mem_wr, mem_rd
    );
endinterface

// File: rtl/qslice_n_fp_sync.sv
// Front-panel button synchroniser (SYNC_STAGES flops) with rising-edge detect.
// An edge is only reported after the button has been seen low since reset.
module fp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;

    // fill_q tracks which sync stages hold real samples; reset zeros are not
    // evidence that the button was released.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
        fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
        prev_d  = sync_q[SYNC_STAGES-1];
        armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/qslice_n.sv
// qslice_n: A/X/P/S register slice with front-panel deposit/examine sequencer.
// Define QSLICE_N_AUTOINC_EN to make deposit/examine auto-increment P.
module qslice_n
    import qslice_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] dbus_i,
    output logic [WIDTH-1:0] dbus_o,
    output logic             dbus_oe,
    output logic [WIDTH-1:0] abus_o,
    output logic             mem_wr,
    output logic             mem_rd,
    input  logic             wra,
    input  logic             rda,
    input  logic             wrx,
    input  logic             rdx,
    input  logic             wrp,
    input  logic             rdp,
    input  logic             incp,
    input  logic             wrs,
    input  logic [1:0]       xsel,
    input  logic             sin,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] x_q,
    output logic [WIDTH-1:0] p_q,
    output logic             sout,
    output logic             p_carry,
    input  logic [WIDTH-1:0] sw,
    input  logic             dep,
    input  logic             exam,
    input  logic             halted,
    output logic             fp_busy
);
    fp_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_d, x_d, p_d;
    logic             s_q, s_d;
    logic             p_carry_q, p_carry_d;
    logic             mem_wr_q, mem_wr_d;
    logic             mem_rd_q, mem_rd_d;
    logic             fp_busy_q, fp_busy_d;
    logic [WIDTH:0]   p_sum;
    logic             cpu_en;
    logic             dep_lvl, dep_rise, exam_lvl, exam_rise;

    fp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dep (
        .clk(clk), .nrst(nrst), .btn_i(dep), .level_o(dep_lvl), .rise_o(dep_rise)
    );

    fp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_exam (
        .clk(clk), .nrst(nrst), .btn_i(exam), .level_o(exam_lvl), .rise_o(exam_rise)
    );

    // The CPU owns the registers only while the panel sequencer is idle.
    assign cpu_en = (state_q == FP_IDLE);
    assign p_sum  = {1'b0, p_q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        a_d = a_q;
        s_d = s_q;
        x_d = x_q;
        p_d = p_q;
        p_carry_d = 1'b0;

        if (cpu_en && wra) a_d = dbus_i;
        if (cpu_en && wrs) s_d = sin;

        if (cpu_en && wrx) begin
            case (xsel_e'(xsel))
                XSEL_ZERO:  x_d = '0;
                XSEL_SHIFT: x_d = {sin, x_q[WIDTH-1:1]};
                XSEL_P:     x_d = p_q;
                XSEL_DBUS:  x_d = dbus_i;
                default:    x_d = x_q;
            endcase
        end else if (state_q == FP_DEP_WR) begin
            x_d = sw;
        end else if (state_q == FP_EXAM_RD) begin
            x_d = dbus_i;
        end

        // A load of P overrides any increment, and so never flags a wrap.
        if (cpu_en && wrp) begin
            p_d = dbus_i;
        end else if ((cpu_en && incp) || state_q == FP_INC) begin
            p_d       = p_sum[WIDTH-1:0];
            p_carry_d = p_sum[WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FP_IDLE: begin
                if (halted && dep_rise)       state_d = FP_DEP_WR;
                else if (halted && exam_rise) state_d = FP_EXAM_RD;
            end
`ifdef QSLICE_N_AUTOINC_EN
            FP_DEP_WR, FP_EXAM_RD: state_d = FP_INC;
`else
            FP_DEP_WR, FP_EXAM_RD: state_d = FP_WAIT_REL;
`endif
            FP_INC: state_d = FP_WAIT_REL;
            FP_WAIT_REL: begin
                if (!dep_lvl && !exam_lvl) state_d = FP_IDLE;
            end
            default: state_d = FP_IDLE;
        endcase

        // Strobes are registered copies of the state being entered.
        mem_wr_d  = (state_d == FP_DEP_WR);
        mem_rd_d  = (state_d == FP_EXAM_RD);
        fp_busy_d = (state_d != FP_IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= FP_IDLE;
            a_q       <= '0;
            x_q       <= '0;
            p_q       <= '0;
            s_q       <= 1'b0;
            p_carry_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
            fp_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            x_q       <= x_d;
            p_q       <= p_d;
            s_q       <= s_d;
            p_carry_q <= p_carry_d;
            mem_wr_q  <= mem_wr_d;
            mem_rd_q  <= mem_rd_d;
            fp_busy_q <= fp_busy_d;
        end
    end

    // Read mux is combinational; gated by nrst so the bus is released in reset.
    always_comb begin
        dbus_o  = '0;
        dbus_oe = 1'b0;
        if (nrst) begin
            if (cpu_en && rda) begin
                dbus_o = a_q;  dbus_oe = 1'b1;
            end else if (cpu_en && rdp) begin
                dbus_o = p_q;  dbus_oe = 1'b1;
            end else if (cpu_en && rdx) begin
                dbus_o = x_q;  dbus_oe = 1'b1;
            end else if (state_q == FP_DEP_WR) begin
                dbus_o = sw;   dbus_oe = 1'b1;
            end
        end
    end

    assign abus_o  = p_q;
    assign sout    = s_q;
    assign p_carry = p_carry_q;
    assign mem_wr  = mem_wr_q;
    assign mem_rd  = mem_rd_q;
    assign fp_busy = fp_busy_q;
endmodule
